// File: rtl/div_arbiter_if.sv
// Requester and divider-side signal bundle for div_arbiter.
// slave is the arbiter view; master is the requester/divider view.
interface div_arbiter_if #(
  parameter int W = 16
);
  logic         req0;
  logic         req1;
  logic [W-1:0] dvd0;
  logic [W-1:0] dvd1;
  logic [W-1:0] dvs0;
  logic [W-1:0] dvs1;
  logic         gnt0;
  logic         gnt1;
  logic         rsp_vld0;
  logic         rsp_vld1;
  logic [W-1:0] quot;
  logic [W-1:0] rem;
  logic         dz;
  logic         err;
  logic         busy;
  logic         div_clr;
  logic         div_bgn;
  logic [W-1:0] div_dvd;
  logic [W-1:0] div_dvs;
  logic         div_fin;
  logic [W-1:0] div_quot;
  logic [W-1:0] div_rem;

  modport slave (
    input  req0, req1, dvd0, dvd1,
    input  dvs0, dvs1,
    input  div_fin, div_quot, div_rem,
    output gnt0, gnt1,
    output rsp_vld0, rsp_vld1,
    output quot, rem, dz, err, busy,
    output div_clr, div_bgn,
    output div_dvd, div_dvs
  );

  modport master (
    output req0, req1, dvd0, dvd1,
    output dvs0, dvs1,
    output div_fin, div_quot, div_rem,
    input  gnt0, gnt1,
    input  rsp_vld0, rsp_vld1,
    input  quot, rem, dz, err, busy,
    input  div_clr, div_bgn,
    input  div_dvd, div_dvs
  );
endinterface

// File: rtl/div_arbiter.sv
// Round-robin arbiter sharing one sequential divider between two
// requesters, with divide-by-zero bypass and a WAIT watchdog.
module div_arbiter #(
  parameter int W   = 16,
  parameter int TMO = 64
) (
  input  logic         clk,
  input  logic         rst,
  div_arbiter_if.slave bus
);

  localparam int CW = $clog2(TMO + 1);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] CLR  = 3'd1;
  localparam logic [2:0] LOAD = 3'd2;
  localparam logic [2:0] WAIT = 3'd3;
  localparam logic [2:0] RESP = 3'd4;

  logic [2:0]    state;
  logic          last;
  logic          owner;
  logic          zp;
  logic [CW-1:0] wd;

  logic          pick;
  logic [W-1:0]  dvd_c;
  logic [W-1:0]  dvs_c;

  always_comb begin
    pick  = (bus.req0 & bus.req1) ? ~last : bus.req1;
    dvd_c = pick ? bus.dvd1 : bus.dvd0;
    dvs_c = pick ? bus.dvs1 : bus.dvs0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      last         <= 1'b1;
      owner        <= 1'b0;
      zp           <= 1'b0;
      wd           <= '0;
      bus.gnt0     <= 1'b0;
      bus.gnt1     <= 1'b0;
      bus.rsp_vld0 <= 1'b0;
      bus.rsp_vld1 <= 1'b0;
      bus.quot     <= '0;
      bus.rem      <= '0;
      bus.dz       <= 1'b0;
      bus.err      <= 1'b0;
      bus.busy     <= 1'b0;
      bus.div_clr  <= 1'b0;
      bus.div_bgn  <= 1'b0;
      bus.div_dvd  <= '0;
      bus.div_dvs  <= '0;
    end else begin
      bus.gnt0     <= 1'b0;
      bus.gnt1     <= 1'b0;
      bus.rsp_vld0 <= 1'b0;
      bus.rsp_vld1 <= 1'b0;
      bus.div_clr  <= 1'b0;
      bus.div_bgn  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req0 | bus.req1) begin
            owner       <= pick;
            last        <= pick;
            bus.gnt0    <= ~pick;
            bus.gnt1    <= pick;
            bus.div_dvd <= dvd_c;
            bus.div_dvs <= dvs_c;
            bus.busy    <= 1'b1;
            if (dvs_c == '0) begin
              zp    <= 1'b1;
              state <= RESP;
            end else begin
              bus.div_clr <= 1'b1;
              state       <= CLR;
            end
          end
        end
        CLR: begin
          bus.div_bgn <= 1'b1;
          state       <= LOAD;
        end
        LOAD: begin
          wd    <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (bus.div_fin) begin
            bus.quot     <= bus.div_quot;
            bus.rem      <= bus.div_rem;
            bus.dz       <= 1'b0;
            bus.err      <= 1'b0;
            bus.rsp_vld0 <= ~owner;
            bus.rsp_vld1 <= owner;
            state        <= RESP;
          end else if (wd == CW'(TMO - 1)) begin
            bus.quot     <= '0;
            bus.rem      <= '0;
            bus.dz       <= 1'b0;
            bus.err      <= 1'b1;
            bus.rsp_vld0 <= ~owner;
            bus.rsp_vld1 <= owner;
            state        <= RESP;
          end else begin
            wd <= wd + CW'(1);
          end
        end
        RESP: begin
          // Zero-divisor ops spend one extra RESP cycle so that
          // the response lands one cycle after the grant.
          if (zp) begin
            zp           <= 1'b0;
            bus.quot     <= '1;
            bus.rem      <= bus.div_dvd;
            bus.dz       <= 1'b1;
            bus.err      <= 1'b0;
            bus.rsp_vld0 <= ~owner;
            bus.rsp_vld1 <= owner;
          end else begin
            bus.busy <= 1'b0;
            state    <= IDLE;
          end
        end
        default: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule
